e_mdu: RTL and testbench

Multi-cycle multiply/divide unit in the E stage, beside the ALU. It takes the same forwarded SrcA/SrcB operands and holds the architectural HI/LO registers. Its MDU_Result is muxed with ALU_Result into the E/M pipeline register. Busy/Start feed the D-stage stall logic so that no later HI/LO instruction leaves D while an operation is in flight.

---
 rtl/e_mdu.sv | 170 +++++++++++++++++
 tb/tb_e_mdu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding architectural HI/LO; results land after a fixed busy window.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  MDU_Control,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Result
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
    localparam logic [3:0] OP_MSUBU = 4'b1100;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q, phi_q, plo_q;
    logic               pwr_q;

    logic               op_mul, op_div, op_sgn, op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic               op_acc, op_sub;
    logic [63:0]        prod_d;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag, quot_d, rem_d;
    logic               a_neg, b_neg;
    logic [31:0]        res_hi_d, res_lo_d;
    logic               wr_ok_d;
    logic [CNT_W-1:0]   cnt_load_d;

    // Opcode decode; unlisted codes fall through as no-ops
    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_sgn  = 1'b0;
        op_acc  = 1'b0;
        op_sub  = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        op_mfhi = 1'b0;
        op_mflo = 1'b0;
        case (MDU_Control)
            OP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
            OP_MULTU: op_mul = 1'b1;
            OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
            OP_DIVU:  op_div = 1'b1;
            OP_MTHI:  op_mthi = 1'b1;
            OP_MTLO:  op_mtlo = 1'b1;
            OP_MFHI:  op_mfhi = 1'b1;
            OP_MFLO:  op_mflo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1; end
            OP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
            OP_MSUB:  begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; op_sgn = 1'b1; end
            OP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign Busy       = (state_q == S_RUN);
    assign Start      = (op_mul | op_div) & ~Req & ~Busy;
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign MDU_Result = op_mfhi ? hi_q : (op_mflo ? lo_q : 32'd0);

    // Low 64 bits of a 64x64 product of the extended operands give the signed/unsigned 32x32 result
    always_comb begin
        if (op_sgn) begin
            prod_d = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
        end else begin
            prod_d = {32'd0, SrcA} * {32'd0, SrcB};
        end
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend
    always_comb begin
        a_neg  = op_sgn & SrcA[31];
        b_neg  = op_sgn & SrcB[31];
        a_mag  = a_neg ? 32'(-SrcA) : SrcA;
        b_mag  = b_neg ? 32'(-SrcB) : SrcB;
        q_mag  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        quot_d = (a_neg ^ b_neg) ? 32'(-q_mag) : q_mag;
        rem_d  = a_neg ? 32'(-r_mag) : r_mag;
    end

    // Pending result selection and completion write-enable
    always_comb begin
        res_hi_d   = prod_d[63:32];
        res_lo_d   = prod_d[31:0];
        wr_ok_d    = 1'b1;
        cnt_load_d = CNT_W'(MULT_CYCLES);
        if (op_div) begin
            res_hi_d   = rem_d;
            res_lo_d   = quot_d;
            wr_ok_d    = (SrcB != 32'd0);
            cnt_load_d = CNT_W'(DIV_CYCLES);
        end else if (op_acc) begin
            if (op_sub) begin
                {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_d;
            end else begin
                {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_d;
            end
        end
    end

    // Operation sequencing and HI/LO state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q <= S_RUN;
                        cnt_q   <= cnt_load_d;
                        phi_q   <= res_hi_d;
                        plo_q   <= res_lo_d;
                        pwr_q   <= wr_ok_d;
                    end else if (!Req) begin
                        if (op_mthi) hi_q <= SrcA;
                        if (op_mtlo) lo_q <= SrcA;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        if (pwr_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO and busy length, a monitor checks on completion.
module tb_e_mdu;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_MULT  = 4'b0001;
    localparam logic [3:0] C_MULTU = 4'b0010;
    localparam logic [3:0] C_DIV   = 4'b0011;
    localparam logic [3:0] C_DIVU  = 4'b0100;
    localparam logic [3:0] C_MTHI  = 4'b0101;
    localparam logic [3:0] C_MTLO  = 4'b0110;
    localparam logic [3:0] C_MFHI  = 4'b0111;
    localparam logic [3:0] C_MFLO  = 4'b1000;
    localparam logic [3:0] C_MADDU = 4'b1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  MDU_Control;
    logic [31:0] SrcA, SrcB;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDU_Result;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .MDU_Control(MDU_Control),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Start      (Start),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO),
        .MDU_Result (MDU_Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one E-stage instruction mid-cycle; combinational outputs settle 1 time unit later
    task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic req);
        @(negedge clk);
        MDU_Control = ctrl;
        SrcA        = a;
        SrcB        = b;
        Req         = req;
        #1;
    endtask

    task automatic wait_done();
        int k = 0;
        issue(C_NONE, 32'd0, 32'd0, 1'b0);
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: %0d results still pending after timeout", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic read_check(input string name, input logic [31:0] hi, input logic [31:0] lo);
        issue(C_MFHI, 32'd0, 32'd0, 1'b0);
        chk({name, "_mfhi"}, MDU_Result, hi);
        issue(C_MFLO, 32'd0, 32'd0, 1'b0);
        chk({name, "_mflo"}, MDU_Result, lo);
    endtask

    task automatic compute(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        issue(ctrl, a, b, 1'b0);
        chk({name, "_start"}, 32'(Start), 32'd1);
        exp_q.push_back('{hi: hi, lo: lo, cycles: cyc});
    endtask

    // Monitor: count busy cycles, and on each busy->idle transition compare HI/LO to the scoreboard
    initial begin
        int   run_cnt   = 0;
        logic busy_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                run_cnt   = 0;
                busy_prev = 1'b0;
            end else begin
                if (Busy) begin
                    run_cnt++;
                end else if (busy_prev) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: completion after %0d busy cycles with nothing pending", run_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_hi", HI, e.hi);
                        chk("done_lo", LO, e.lo);
                        chk("busy_len", 32'(run_cnt), 32'(e.cycles));
                    end
                    run_cnt = 0;
                end
                busy_prev = Busy;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        Req         = 1'b0;
        MDU_Control = C_NONE;
        SrcA        = 32'd0;
        SrcB        = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // -2 * 3 = -6; a compute op presented while busy must be ignored
        compute("mult", C_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(C_DIV, 32'd1, 32'd1, 1'b0);
        chk("busy_after_start", 32'(Busy), 32'd1);
        chk("start_while_busy", 32'(Start), 32'd0);
        wait_done();
        read_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        compute("divu", C_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        wait_done();
        read_check("divu", 32'd1, 32'd3);

        compute("div", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_done();
        read_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        compute("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        wait_done();
        read_check("div_ovf", 32'd0, 32'h8000_0000);

        // mthi is not visible in its own cycle, visible the next
        issue(C_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_same_cycle_hi", HI, 32'd0);
        chk("mthi_result_zero", MDU_Result, 32'd0);
        issue(C_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mthi_next_cycle", MDU_Result, 32'h1234_5678);
        issue(C_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(C_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mthi_req_blocked", MDU_Result, 32'h1234_5678);
        issue(C_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(C_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mtlo_req_blocked", MDU_Result, 32'h8000_0000);

        // Divide by zero keeps HI/LO after the full busy window
        issue(C_MTHI, 32'h0000_000A, 32'd0, 1'b0);
        issue(C_MTLO, 32'h0000_000B, 32'd0, 1'b0);
        compute("div0", C_DIV, 32'd5, 32'd0, 32'h0000_000A, 32'h0000_000B, 10);
        wait_done();
        read_check("div0", 32'h0000_000A, 32'h0000_000B);

        issue(C_MULTU, 32'd3, 32'd4, 1'b1);
        chk("multu_req_start", 32'(Start), 32'd0);
        issue(C_NONE, 32'd0, 32'd0, 1'b0);
        chk("multu_req_busy", 32'(Busy), 32'd0);

        // Reset during the second busy cycle aborts the operation
        issue(C_MULT, 32'd3, 32'd4, 1'b0);
        chk("abort_start", 32'(Start), 32'd1);
        issue(C_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("abort_later_hi", HI, 32'd0);
        chk("abort_later_lo", LO, 32'd0);
        chk("abort_later_busy", 32'(Busy), 32'd0);

        issue(C_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        compute("maddu", C_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5);
        wait_done();
        read_check("maddu", 32'd1, 32'd0);
`else
        issue(C_MADDU, 32'd1, 32'd1, 1'b0);
        chk("maddu_off_start", 32'(Start), 32'd0);
        issue(C_NONE, 32'd0, 32'd0, 1'b0);
        chk("maddu_off_busy", 32'(Busy), 32'd0);
        read_check("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
